mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 14: byte-address width of the attached SRAM (16 KiB); word address = addr[ADDR_BITS-1:2].
REQ-002 Parameter WAIT, default 2, range 0-15: extra wait cycles per SRAM access.
REQ-003 clock  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_read  in  1  core read request.
REQ-006 mem_write  in  1  core write request.
REQ-007 addr  in  32  byte address from core.
REQ-008 mem_wrbits  in  4  byte-lane write mask; bit i = byte lane i (bits 8i+7:8i).
REQ-009 wdata  in  32  write data, lane-aligned.
REQ-010 rdata  out  32  read data, registered.
REQ-011 ready  out  1  one-cycle completion pulse.
REQ-012 error  out  1  one-cycle error flag, asserted only together with ready.
REQ-013 sram_cs  out  1  SRAM chip select, registered.
REQ-014 sram_we  out  1  SRAM write enable, registered.
REQ-015 sram_addr  out  ADDR_BITS-2  SRAM word address, registered.
REQ-016 sram_be  out  4  SRAM byte enables, registered.
REQ-017 sram_wdata  out  32  SRAM write data, registered.
REQ-018 sram_rdata  in  32  SRAM read data, valid the cycle after sram_cs is sampled.

Function
REQ-019 FSM states IDLE, ACCESS, WAIT, DONE; only IDLE accepts requests.
REQ-020 IDLE: mem_read or mem_write high at a rising edge accepts the request and latches addr, mem_wrbits, wdata, and request type.
REQ-021 Valid request: IDLE -> ACCESS; sram_cs=1, sram_addr=addr[ADDR_BITS-1:2], for exactly the ACCESS cycle.
REQ-022 Read: sram_we=0, sram_be=4'b1111; write: sram_we=(mem_wrbits!=0), sram_be=mem_wrbits, sram_wdata=wdata.
REQ-023 ACCESS -> WAIT when WAIT>0, else -> DONE; WAIT holds a down-counter loaded with WAIT and -> DONE when it reaches 1; sram_cs=0 throughout WAIT.
REQ-024 Read data sram_rdata is captured into rdata on the edge leaving ACCESS and presented while ready=1.
REQ-025 DONE: ready=1 for one cycle, then -> IDLE unconditionally.
REQ-026 Latency from accepting edge to ready: 2+WAIT cycles (valid request); 1 cycle (error).
REQ-027 Error cases, decided at acceptance, SRAM untouched (sram_cs stays 0), IDLE -> DONE, error=1 with ready: addr[31:ADDR_BITS]!=0; mem_read and mem_write both high; read with addr[1:0]!=0.
REQ-028 Write with mem_wrbits=0: full access timing, sram_cs=1, sram_we=0, no error.
REQ-029 rdata holds its value until the next successful read completes; writes and errors leave it unchanged.
REQ-030 Input changes while not IDLE are ignored; latched request values govern the access.
REQ-031 Requester deasserts mem_read/mem_write by the edge following ready; a request still high in IDLE is a new request.

Reset
REQ-032 reset=1 at an edge: state=IDLE, counter=0, ready=0, error=0, rdata=0, sram_cs=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0.
REQ-033 Reset mid-operation aborts the transaction without ready; a write whose ACCESS cycle coincides with the reset edge commits, none later.
REQ-034 Requests present while reset=1 are not accepted.

Verification
REQ-035 WAIT=2, read addr=0x0000_0010, SRAM word 4 = 0xDEAD_BEEF -> sram_cs one cycle, addr 4, be 4'b1111; ready at +4 with rdata=0xDEAD_BEEF, error=0.
REQ-036 Write addr=0x0000_0020, wdata=0x1122_3344, wrbits=4'b0101 -> sram_we=1, be=4'b0101, sram_addr=8; readback yields old lanes 3,1 and 0x22,0x44 in lanes 2,0.
REQ-037 Read addr=0x0001_0000 (ADDR_BITS=14) -> no sram_cs, ready and error both 1 one cycle after acceptance, rdata unchanged.
REQ-038 mem_read=mem_write=1 -> error response in 1 cycle; write with wrbits=0 -> sram_we=0, ready at +2+WAIT, error=0.
REQ-039 WAIT=0 back-to-back reads (request dropped and reasserted) -> ready every 3rd cycle; WAIT=15 -> ready at +17.
REQ-040 Reset asserted during WAIT of a read -> no ready pulse, all outputs 0 next cycle, next request serviced normally.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Bridges a simple core memory request (read/write strobes with
//               a byte address) to a single-port synchronous SRAM with a
//               configurable number of wait cycles per access.
//               Out-of-range, conflicting and misaligned-read requests are
//               answered with an error pulse without touching the SRAM.
//
// Parameters  : ADDR_BITS  byte-address width of the attached SRAM
//               WAIT       extra wait cycles per SRAM access (0..15)
//
// Ports       : clock, reset            system clock, sync active-high reset
//               mem_read, mem_write     core request strobes
//               addr, mem_wrbits, wdata core address, lane mask, write data
//               rdata, ready, error     registered read data, completion and
//                                       error pulses (error only with ready)
//               sram_cs, sram_we        registered SRAM strobes
//               sram_addr, sram_be      registered SRAM word address, lanes
//               sram_wdata, sram_rdata  SRAM write / read data
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_responder #(
    parameter int ADDR_BITS = 14,
    parameter int WAIT      = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          addr,
    input  logic [3:0]           mem_wrbits,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 ready,
    output logic                 error,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [ADDR_BITS-3:0] sram_addr,
    output logic [3:0]           sram_be,
    output logic [31:0]          sram_wdata,
    input  logic [31:0]          sram_rdata
);

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_accept;
    logic       w_req_bad;
    logic       w_addr_out_of_range;
    logic       r_err;
    logic       r_is_read;

    // Any address bit at or above ADDR_BITS lies outside the attached SRAM.
    assign w_addr_out_of_range = |(addr >> ADDR_BITS);

    // Errors are decided once, at acceptance, from the live request inputs.
    assign w_req_bad = w_addr_out_of_range
                     | (mem_read & mem_write)
                     | (mem_read & (addr[1:0] != 2'b00));

    // Completion is a decode of the DONE state, so it lasts exactly one cycle.
    assign ready = (r_state == S_DONE);
    assign error = (r_state == S_DONE) & r_err;

    // ------------------------------------------------------------------------
    // State and wait-counter register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    w_accept     = 1'b1;
                    w_state_next = w_req_bad ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (WAIT > 0) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = c_WAIT_LOAD;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_WAIT: begin
                // Counter is loaded with WAIT, so leaving at 1 yields exactly
                // WAIT cycles in this state.
                if (r_cnt <= 4'd1) begin
                    w_state_next = S_DONE;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request latch, SRAM strobes and read-data capture
    // The SRAM port registers double as the request latch: they are loaded
    // only at acceptance, so input changes while busy have no effect.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err      <= 1'b0;
            r_is_read  <= 1'b0;
            rdata      <= 32'd0;
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_be    <= 4'd0;
            sram_wdata <= 32'd0;
        end else begin
            // Chip select and write enable are single-cycle strobes that
            // cover only the ACCESS state.
            sram_cs <= 1'b0;
            sram_we <= 1'b0;

            if (w_accept) begin
                r_err     <= w_req_bad;
                r_is_read <= mem_read;
                if (!w_req_bad) begin
                    sram_cs   <= 1'b1;
                    sram_addr <= addr[ADDR_BITS-1:2];
                    if (mem_read) begin
                        sram_be <= 4'b1111;
                    end else begin
                        // An empty lane mask still runs a full access cycle
                        // but never asserts the write strobe.
                        sram_we    <= (mem_wrbits != 4'd0);
                        sram_be    <= mem_wrbits;
                        sram_wdata <= wdata;
                    end
                end
            end

            // The SRAM presents read data during the ACCESS cycle; capture it
            // on the edge leaving ACCESS. Writes and errors leave rdata alone.
            if ((r_state == S_ACCESS) && r_is_read) begin
                rdata <= sram_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed stimulus for mem_responder with a queue of expected
//               responses consumed by an independent response monitor.
//               Main instance uses WAIT=2; two small instances cover WAIT=0
//               and WAIT=15 timing.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // Main instance (ADDR_BITS=14, WAIT=2)
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [3:0]  mem_wrbits = 4'd0;
    logic [31:0] rdata, sram_wdata, sram_rdata;
    logic        ready, error, sram_cs, sram_we;
    logic [11:0] sram_addr;
    logic [3:0]  sram_be;

    // WAIT=0 instance
    logic        w0_read = 1'b0;
    logic [31:0] w0_addr = 32'd0;
    logic [31:0] w0_rdata, w0_swdata, w0_srdata;
    logic        w0_ready, w0_error, w0_cs, w0_we;
    logic [11:0] w0_saddr;
    logic [3:0]  w0_be;

    // WAIT=15 instance
    logic        w15_read = 1'b0;
    logic [31:0] w15_addr = 32'd0;
    logic [31:0] w15_rdata, w15_swdata, w15_srdata;
    logic        w15_ready, w15_error, w15_cs, w15_we;
    logic [11:0] w15_saddr;
    logic [3:0]  w15_be;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          at;
    } exp_t;
    exp_t sb[$];

    logic [31:0] mem [0:4095];
    logic        prev_cs = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_responder #(.ADDR_BITS(14), .WAIT(2)) u_dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .mem_wrbits(mem_wrbits), .wdata(wdata), .rdata(rdata),
        .ready(ready), .error(error), .sram_cs(sram_cs), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_be(sram_be), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    mem_responder #(.ADDR_BITS(14), .WAIT(0)) u_w0 (
        .clock(clock), .reset(reset), .mem_read(w0_read), .mem_write(1'b0),
        .addr(w0_addr), .mem_wrbits(4'd0), .wdata(32'd0), .rdata(w0_rdata),
        .ready(w0_ready), .error(w0_error), .sram_cs(w0_cs), .sram_we(w0_we),
        .sram_addr(w0_saddr), .sram_be(w0_be), .sram_wdata(w0_swdata),
        .sram_rdata(w0_srdata)
    );

    mem_responder #(.ADDR_BITS(14), .WAIT(15)) u_w15 (
        .clock(clock), .reset(reset), .mem_read(w15_read), .mem_write(1'b0),
        .addr(w15_addr), .mem_wrbits(4'd0), .wdata(32'd0), .rdata(w15_rdata),
        .ready(w15_ready), .error(w15_error), .sram_cs(w15_cs), .sram_we(w15_we),
        .sram_addr(w15_saddr), .sram_be(w15_be), .sram_wdata(w15_swdata),
        .sram_rdata(w15_srdata)
    );

    // SRAM model: read data follows the registered word address, writes
    // commit at the edge that samples cs/we.
    assign sram_rdata = mem[sram_addr];
    assign w0_srdata  = 32'hC0DE_0000 | {20'd0, w0_saddr};
    assign w15_srdata = 32'hF00D_0000 | {20'd0, w15_saddr};

    always @(posedge clock) begin
        if (cyc == 0) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h1000_0000 + i;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'hAABB_CCDD;
        end else if (sram_cs && sram_we) begin
            for (int b = 0; b < 4; b++)
                if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Response monitor
    always @(negedge clock) begin : mon
        exp_t e;
        if (error) chk("error_only_with_ready", {31'd0, ready}, 32'd1);
        if (ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("resp_error", {31'd0, error}, {31'd0, e.err});
                chk("resp_rdata", rdata, e.rd);
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    // Chip select must never stay high for two consecutive cycles.
    always @(negedge clock) begin
        if (sram_cs) chk("cs_single_cycle", {31'd0, prev_cs}, 32'd0);
        prev_cs <= sram_cs;
    end

    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] wb, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_rd,
                          input int lat, input bit scramble);
        bit got;
        @(negedge clock);
        mem_read = rd; mem_write = wr; addr = a; mem_wrbits = wb; wdata = wd;
        @(posedge clock);
        #1;
        sb.push_back('{err: e_err, rd: e_rd, at: cyc + lat - 1});
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; mem_wrbits = 4'd0; wdata = 32'd0;
        if (scramble) begin
            // Busy-time input activity that must be ignored.
            mem_write = 1'b1; addr = 32'h10; mem_wrbits = 4'hF; wdata = 32'h0;
        end
        if (!e_err) begin
            chk("sram_cs", {31'd0, sram_cs}, 32'd1);
            chk("sram_addr", {20'd0, sram_addr}, {20'd0, a[13:2]});
            chk("sram_we", {31'd0, sram_we}, {31'd0, (!rd && wb != 4'd0)});
            chk("sram_be", {28'd0, sram_be}, {28'd0, (rd ? 4'hF : wb)});
            if (wr) chk("sram_wdata", sram_wdata, wd);
        end else begin
            chk("err_no_cs", {31'd0, sram_cs}, 32'd0);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = ready;
        end
        chk("ready_timeout", {31'd0, got}, 32'd1);
        mem_write = 1'b0; addr = 32'd0; mem_wrbits = 4'd0;
        @(posedge clock);
    endtask

    task automatic abort_read();
        @(negedge clock);
        mem_read = 1'b1; addr = 32'h10;
        @(posedge clock);
        #1;
        mem_read = 1'b0; addr = 32'd0;
        @(posedge clock);            // now in the wait phase
        @(negedge clock);
        reset = 1'b1;
        mem_read = 1'b1;             // request held during reset
        @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_cs", {31'd0, sram_cs}, 32'd0);
        chk("rst_we", {31'd0, sram_we}, 32'd0);
        chk("rst_be", {28'd0, sram_be}, 32'd0);
        chk("rst_addr", {20'd0, sram_addr}, 32'd0);
        chk("rst_wdata", sram_wdata, 32'd0);
        @(posedge clock);
        #1;
        chk("rst_req_ignored", {31'd0, sram_cs}, 32'd0);
        @(negedge clock);
        reset = 1'b0; mem_read = 1'b0;
        repeat (6) @(negedge clock);
    endtask

    task automatic write_reset_at_access();
        @(negedge clock);
        mem_write = 1'b1; addr = 32'h40; wdata = 32'h0BAD_CAFE; mem_wrbits = 4'hF;
        @(posedge clock);
        #1;
        mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; mem_wrbits = 4'd0;
        chk("wr_rst_cs", {31'd0, sram_cs}, 32'd1);
        chk("wr_rst_we", {31'd0, sram_we}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("wr_rst_cs_cleared", {31'd0, sram_cs}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic run_w0();
        int  rc[3];
        int  acc0;
        bit  got;
        acc0 = 0;
        @(negedge clock);
        w0_read = 1'b1; w0_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            if (k == 0) acc0 = cyc;
            w0_read = 1'b0;
            got = 1'b0;
            rc[k] = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clock);
                if (w0_ready) begin
                    got = 1'b1;
                    rc[k] = cyc;
                end
            end
            chk("w0_ready_timeout", {31'd0, got}, 32'd1);
            chk("w0_rdata", w0_rdata, 32'hC0DE_0000 + k);
            @(posedge clock);
            #1;
            if (k < 2) begin
                w0_read = 1'b1;
                w0_addr = 32'(4 * (k + 1));
            end
        end
        chk("w0_first_latency", rc[0] + 1 - acc0, 32'd2);
        chk("w0_spacing_a", rc[1] - rc[0], 32'd3);
        chk("w0_spacing_b", rc[2] - rc[1], 32'd3);
    endtask

    task automatic run_w15();
        int acc;
        int rc;
        bit got;
        @(negedge clock);
        w15_read = 1'b1; w15_addr = 32'h8;
        @(posedge clock);
        #1;
        acc = cyc;
        w15_read = 1'b0;
        got = 1'b0;
        rc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            if (w15_ready) begin
                got = 1'b1;
                rc = cyc;
            end
        end
        chk("w15_ready_timeout", {31'd0, got}, 32'd1);
        chk("w15_latency", rc + 1 - acc, 32'd17);
        chk("w15_rdata", w15_rdata, 32'hF00D_0002);
        chk("w15_error", {31'd0, w15_error}, 32'd0);
        @(posedge clock);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("init_ready", {31'd0, ready}, 32'd0);
        chk("init_error", {31'd0, error}, 32'd0);
        chk("init_rdata", rdata, 32'd0);
        chk("init_cs", {31'd0, sram_cs}, 32'd0);
        chk("init_we", {31'd0, sram_we}, 32'd0);
        chk("init_be", {28'd0, sram_be}, 32'd0);
        chk("init_addr", {20'd0, sram_addr}, 32'd0);
        chk("init_wdata", sram_wdata, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);

        //     rd    wr    addr            wb    wdata           err   rdata           lat scr
        do_req(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,          1'b0, 32'hDEAD_BEEF, 4,  1'b0);
        do_req(1'b0, 1'b1, 32'h0000_0020, 4'h5, 32'h1122_3344,  1'b0, 32'hDEAD_BEEF, 4,  1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0020, 4'h0, 32'h0,          1'b0, 32'hAA22_CC44, 4,  1'b0);
        do_req(1'b1, 1'b0, 32'h0001_0000, 4'h0, 32'h0,          1'b1, 32'hAA22_CC44, 1,  1'b0);
        do_req(1'b1, 1'b1, 32'h0000_0024, 4'hF, 32'h5555_5555,  1'b1, 32'hAA22_CC44, 1,  1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0022, 4'h0, 32'h0,          1'b1, 32'hAA22_CC44, 1,  1'b0);
        do_req(1'b1, 1'b0, 32'h0000_4000, 4'h0, 32'h0,          1'b1, 32'hAA22_CC44, 1,  1'b0);
        do_req(1'b0, 1'b1, 32'h0000_0030, 4'h0, 32'hFFFF_FFFF,  1'b0, 32'hAA22_CC44, 4,  1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0030, 4'h0, 32'h0,          1'b0, 32'h1000_000C, 4,  1'b0);
        do_req(1'b0, 1'b1, 32'h0000_3FFC, 4'hF, 32'hCAFE_F00D,  1'b0, 32'h1000_000C, 4,  1'b0);
        do_req(1'b1, 1'b0, 32'h0000_3FFC, 4'h0, 32'h0,          1'b0, 32'hCAFE_F00D, 4,  1'b1);

        abort_read();
        do_req(1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,          1'b0, 32'hDEAD_BEEF, 4,  1'b0);
        write_reset_at_access();
        do_req(1'b1, 1'b0, 32'h0000_0040, 4'h0, 32'h0,          1'b0, 32'h0BAD_CAFE, 4,  1'b0);
        do_req(1'b1, 1'b0, 32'h0000_0003, 4'h0, 32'h0,          1'b1, 32'h0BAD_CAFE, 1,  1'b0);

        run_w0();
        run_w15();

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
